// File: rtl/uart_tx_arb_if.sv
// Bundle between the round-robin UART byte arbiter and its surroundings.
// The slave side is the arbiter itself; the master side holds the requesters and the transmitter.
interface uart_tx_arb_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      gnt;
    logic                 tx_start;
    logic [7:0]           tx_din;
    logic                 tx_done_tick;
    logic                 busy;
    logic [IW-1:0]        grant_id;
    logic [15:0]          sent_cnt;

    modport slave (
        input  req, req_data, tx_done_tick,
        output gnt, tx_start, tx_din, busy, grant_id, sent_cnt
    );

    modport master (
        output req, req_data, tx_done_tick,
        input  gnt, tx_start, tx_din, busy, grant_id, sent_cnt
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds bytes from NREQ requesters into one shared UART
// transmitter. It is a three-state FSM, and every output is registered.
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_arb_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

    state_e          state_q, state_d;
    logic [DBIT-1:0] data_reg_q, data_reg_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   last_id_q, last_id_d;
    logic [15:0]     sent_cnt_q, sent_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_din_q, tx_din_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   win;
    logic            found;
    int              idx;

    // Search starts just past the last served requester and wraps around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_id_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_reg_d = data_reg_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        sent_cnt_d = sent_cnt_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d             = START;
                    data_reg_d          = bus.req_data[int'(win)*DBIT +: DBIT];
                    grant_id_d          = win;
                    gnt_d[win]          = 1'b1;
                    tx_start_d          = 1'b1;
                    tx_din_d            = '0;
                    tx_din_d[DBIT-1:0]  = bus.req_data[int'(win)*DBIT +: DBIT];
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done_tick) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                    if (sent_cnt_q != 16'hFFFF) sent_cnt_d = sent_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_reg_q <= '0;
            grant_id_q <= '0;
            last_id_q  <= IW'(NREQ - 1);
            sent_cnt_q <= '0;
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_reg_q <= data_reg_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            sent_cnt_q <= sent_cnt_d;
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;
    assign bus.sent_cnt = sent_cnt_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb. Inputs change and outputs are checked on the falling
// clock edge, half a period away from the edge the design samples on.
module tb_uart_tx_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passes = 0;
    int   total  = 0;
    logic [7:0] dat [4] = '{8'hA5, 8'hC3, 8'h5A, 8'h3C};

    uart_tx_arb_if #(.NREQ(4), .DBIT(8)) bus ();
    uart_tx_arb #(.NREQ(4), .DBIT(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (bus.gnt == 4'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_timeout", {31'b0, bus.gnt != 4'b0}, 32'd1);
    endtask

    // One full transfer: request, grant/start pulse, WAIT, done tick, back to IDLE.
    task automatic xfer(input logic [3:0] r, input logic [3:0] r_after, input int id,
                        input logic [15:0] cnt);
        bus.req = r;
        wait_gnt();
        chk("gnt",      bus.gnt,      32'(4'b0001 << id));
        chk("tx_start", bus.tx_start, 32'd1);
        chk("tx_din",   bus.tx_din,   dat[id]);
        chk("grant_id", bus.grant_id, id);
        chk("busy_st",  bus.busy,     32'd1);
        bus.req = r_after;
        @(negedge clk);
        chk("gnt_wait",   bus.gnt,      32'd0);
        chk("start_wait", bus.tx_start, 32'd0);
        chk("din_hold",   bus.tx_din,   dat[id]);
        chk("busy_wait",  bus.busy,     32'd1);
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        chk("sent_cnt",  bus.sent_cnt, cnt);
        chk("busy_done", bus.busy,     32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req          = '0;
        bus.req_data     = {dat[3], dat[2], dat[1], dat[0]};
        bus.tx_done_tick = 1'b0;
        do_reset();
        chk("rst_gnt",   bus.gnt,      32'd0);
        chk("rst_start", bus.tx_start, 32'd0);
        chk("rst_din",   bus.tx_din,   32'd0);
        chk("rst_busy",  bus.busy,     32'd0);
        chk("rst_gid",   bus.grant_id, 32'd0);
        chk("rst_cnt",   bus.sent_cnt, 32'd0);

        // Single requester 0 with byte A5.
        xfer(4'b0001, 4'b0000, 0, 16'd1);

        // All four requesting continuously: strict rotation 0..3 twice.
        do_reset();
        for (int i = 0; i < 8; i++) xfer(4'b1111, 4'b1111, i % 4, 16'(i + 1));
        bus.req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // After requester 2, the wrap skips idle requester 3 and lands on 0, then 1.
        xfer(4'b0100, 4'b0000, 2, 16'd9);
        xfer(4'b0011, 4'b0010, 0, 16'd10);
        xfer(4'b0010, 4'b0000, 1, 16'd11);

        // A tick in IDLE and a tick during START are both ignored.
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        chk("idle_tick_busy", bus.busy,     32'd0);
        chk("idle_tick_cnt",  bus.sent_cnt, 32'd11);
        bus.req = 4'b1000;
        wait_gnt();
        chk("gnt3", bus.gnt, 32'h8);
        bus.req = 4'b0000;
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        chk("start_tick_busy", bus.busy,     32'd1);
        chk("start_tick_cnt",  bus.sent_cnt, 32'd11);
        @(negedge clk);
        chk("still_wait", bus.busy, 32'd1);
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        chk("wait_tick_cnt",  bus.sent_cnt, 32'd12);
        chk("wait_tick_busy", bus.busy,     32'd0);

        // Reset during START: no pulse survives into the next cycle.
        bus.req = 4'b0001;
        wait_gnt();
        chk("gnt0_pre_abort", bus.gnt, 32'h1);
        reset   = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_gnt",   bus.gnt,      32'd0);
        chk("abort_start", bus.tx_start, 32'd0);
        chk("abort_busy",  bus.busy,     32'd0);

        // Reset during WAIT with grant_id=2, colliding with a tick and a request.
        bus.req = 4'b0100;
        wait_gnt();
        bus.req = 4'b0000;
        @(negedge clk);
        chk("wait_gid2", bus.grant_id, 32'd2);
        reset = 1'b1;
        bus.tx_done_tick = 1'b1;
        bus.req = 4'b0001;
        @(negedge clk);
        reset = 1'b0;
        bus.tx_done_tick = 1'b0;
        bus.req = 4'b0000;
        chk("rw_gnt",   bus.gnt,      32'd0);
        chk("rw_start", bus.tx_start, 32'd0);
        chk("rw_din",   bus.tx_din,   32'd0);
        chk("rw_gid",   bus.grant_id, 32'd0);
        chk("rw_busy",  bus.busy,     32'd0);
        chk("rw_cnt",   bus.sent_cnt, 32'd0);
        @(negedge clk);
        chk("rw_no_stray", bus.gnt, 32'd0);
        xfer(4'b0100, 4'b0000, 2, 16'd1);

        // Counter saturation from FFFE.
        force dut.sent_cnt_q = 16'hFFFE;
        #1;
        release dut.sent_cnt_q;
        @(negedge clk);
        chk("forced_cnt", bus.sent_cnt, 32'hFFFE);
        xfer(4'b0001, 4'b0000, 0, 16'hFFFF);
        xfer(4'b0010, 4'b0000, 1, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter DBIT, default 8, data width per byte; legal range 5..8.
REQ-003 Port clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 Port req  input  NREQ  per-requester transmit request; bit i high = byte pending from requester i.
REQ-006 Port req_data  input  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT].
REQ-007 Port gnt  output  NREQ  one-hot, one-cycle pulse; the byte from requester i has been captured.
REQ-008 Port tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 Port tx_din  output  8  byte to the transmitter; zero-extended when DBIT<8.
REQ-010 Port tx_done_tick  input  1  transmitter completion pulse.
REQ-011 Port busy  output  1  high in every state other than IDLE.
REQ-012 Port grant_id  output  $clog2(NREQ)  index of the requester currently owning the transmitter.
REQ-013 Port sent_cnt  output  16  bytes completed since reset; saturates at 16'hFFFF.

Function
REQ-014 FSM states IDLE, START and WAIT; all outputs registered.
REQ-015 IDLE, with req != 0 at edge N: select the winner, latch its req_data into data_reg, latch grant_id, then go to START.
REQ-016 Cycle N+1 (START): gnt[winner]=1 and tx_start=1 for exactly one cycle, tx_din=data_reg; next state WAIT.
REQ-017 WAIT: tx_din holds data_reg; on tx_done_tick=1, last_id<=grant_id, sent_cnt increments (saturating), state goes to IDLE.
REQ-018 tx_done_tick is ignored in IDLE and START.
REQ-019 Round-robin selection: search from (last_id+1) mod NREQ upward with wrap; the first set req bit wins.
REQ-020 Exactly one grant per byte.
REQ-021 Minimum spacing between consecutive tx_start pulses is done-to-start = 2 cycles (WAIT->IDLE, IDLE->START).
REQ-022 Requester contract: hold req and req_data stable until it sees gnt, then drop req, or present the next byte on the following cycle.
REQ-023 req is not sampled in START or WAIT, so a req still high during the gnt cycle creates no duplicate.
REQ-024 A requester that drops req before it is granted is simply not selected; no other side effect.
REQ-025 A single active requester re-asserting req continuously is served back to back, with the REQ-021 spacing.
REQ-026 gnt is all-zero outside START; tx_start is 0 outside START.
REQ-027 grant_id and tx_din remain stable from START until leaving WAIT.

Reset
REQ-028 Reset values: state IDLE, gnt=0, tx_start=0, tx_din=0, data_reg=0, grant_id=0, busy=0, sent_cnt=0, last_id=NREQ-1 (requester 0 has first priority).
REQ-029 Reset asserted mid-operation (START or WAIT) aborts immediately; no gnt or tx_start pulse is issued in the following cycle.
REQ-030 Reset has priority over all inputs on the same edge, including req and tx_done_tick.

Verification
REQ-031 After reset, req=4'b0001, req_data[7:0]=8'hA5:
- gnt=4'b0001 and tx_start=1 exactly one cycle later, with tx_din=8'hA5.
- After tx_done_tick, sent_cnt=1 and busy=0.
REQ-032 After reset, req=4'b1111 held continuously (with REQ-022 refreshes), 8 done ticks:
- grant order is 0,1,2,3,0,1,2,3.
- sent_cnt=8.
REQ-033 After a requester-2 transaction, req=4'b0011:
- requester 0 wins first (wrap from last_id=2 skips 3).
- requester 1 wins second.
REQ-034 tx_done_tick pulsed while IDLE and again during START:
- ignored both times: no state change, sent_cnt unchanged.
- The transfer completes only on a tick in WAIT.
REQ-035 Reset asserted in WAIT with grant_id=2:
- the next cycle shows the full REQ-028 values.
- A subsequent req=4'b0100 is granted to requester 2.
REQ-036 Saturation: force sent_cnt to 16'hFFFE, then complete 2 transfers:
- sent_cnt=16'hFFFF after both transfers.
- No wrap to 0.
